// File: rtl/cdc_slow_to_fast.sv
// Single-bit slow-to-fast crossing: multi-flop synchronizer on clk_f
// followed by a registered edge detector producing one-cycle pulses.
`timescale 1ns/1ps

module cdc_slow_to_fast #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0
) (
   input  logic clk_f,
   input  logic rst_n,
   input  logic clk_s,
   input  logic pluse_s,
   output logic pluse_f,
   output logic level_f
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("cdc_slow_to_fast: SYNC_STAGES must be 2..4");
   end

   if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("cdc_slow_to_fast: EDGE_MODE must be 0, 1 or 2");
   end

   // clk_s is interface-only; it must never reach a flop or data path
   logic unused_clk_s;
   assign unused_clk_s = clk_s;

   (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   logic hist_q;
   logic hist_d;
   logic pulse_q;
   logic pulse_d;
   logic last;

   assign last   = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], pluse_s};
   assign hist_d = last;

   always_comb begin
      pulse_d = 1'b0;
      case (EDGE_MODE)
         0:       pulse_d = last & ~hist_q;
         1:       pulse_d = ~last & hist_q;
         default: pulse_d = last ^ hist_q;
      endcase
   end

   always_ff @(posedge clk_f) begin
      if (!rst_n) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         pulse_q <= pulse_d;
      end
   end

   assign pluse_f = pulse_q;
   assign level_f = last;

endmodule

// File: tb/tb_cdc_slow_to_fast.sv
// Directed bench for cdc_slow_to_fast across four parameter sets
// sharing one clock, reset and input.
`timescale 1ns/1ps

module tb_cdc_slow_to_fast;

   logic clk_f = 1'b0;
   logic clk_s = 1'b0;
   logic rst_n = 1'b0;
   logic pluse_s = 1'b0;
   logic [3:0] pf;
   logic [3:0] lf;

   int checks = 0;
   int errors = 0;
   int ecnt = 0;
   int pcnt [4];
   int wide [4];
   int lvl [4];
   int pe [4][64];
   logic [3:0] prev = '0;

   int b [4];
   int w [4];
   int l [4];
   int cr, cf, rel;
   int cr6 [10];

   always #17.5 clk_f = ~clk_f;
   always #50 clk_s = ~clk_s;

   // idx0: 2 stages rising, idx1: 2 stages both,
   // idx2: 3 stages falling, idx3: 4 stages rising
   cdc_slow_to_fast #(.SYNC_STAGES(2), .EDGE_MODE(0)) u0 (
      .clk_f(clk_f), .rst_n(rst_n), .clk_s(clk_s),
      .pluse_s(pluse_s), .pluse_f(pf[0]), .level_f(lf[0]));
   cdc_slow_to_fast #(.SYNC_STAGES(2), .EDGE_MODE(2)) u1 (
      .clk_f(clk_f), .rst_n(rst_n), .clk_s(clk_s),
      .pluse_s(pluse_s), .pluse_f(pf[1]), .level_f(lf[1]));
   cdc_slow_to_fast #(.SYNC_STAGES(3), .EDGE_MODE(1)) u2 (
      .clk_f(clk_f), .rst_n(rst_n), .clk_s(clk_s),
      .pluse_s(pluse_s), .pluse_f(pf[2]), .level_f(lf[2]));
   cdc_slow_to_fast #(.SYNC_STAGES(4), .EDGE_MODE(0)) u3 (
      .clk_f(clk_f), .rst_n(rst_n), .clk_s(clk_s),
      .pluse_s(pluse_s), .pluse_f(pf[3]), .level_f(lf[3]));

   initial begin
      for (int k = 0; k < 4; k++) begin
         pcnt[k] = 0;
         wide[k] = 0;
         lvl[k] = 0;
      end
   end

   always @(posedge clk_f) ecnt <= ecnt + 1;

   always @(negedge clk_f) begin
      for (int k = 0; k < 4; k++) begin
         if (pf[k] === 1'b1 && prev[k] !== 1'b1 && pcnt[k] < 64) begin
            pe[k][pcnt[k]] <= ecnt;
            pcnt[k] <= pcnt[k] + 1;
         end
         if (pf[k] === 1'b1 && prev[k] === 1'b1)
            wide[k] <= wide[k] + 1;
         if (lf[k] === 1'b1)
            lvl[k] <= lvl[k] + 1;
      end
      prev <= pf;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic rng(input string tag, input int obs,
                      input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d",
                tag, obs, lo, hi);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_f);
      #1;
   endtask

   task automatic snap();
      for (int k = 0; k < 4; k++) begin
         b[k] = pcnt[k];
         w[k] = wide[k];
         l[k] = lvl[k];
      end
   endtask

   initial begin
      // reset behaviour
      rst_n = 1'b0;
      pluse_s = 1'b0;
      cyc(3);
      chk("rst_pf", int'(pf), 0);
      chk("rst_lf", int'(lf), 0);
      rst_n = 1'b1;
      snap();
      cyc(10);
      chk("idle_pf_now", int'(pf), 0);
      chk("idle_lf", int'(lf), 0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("idle_cnt%0d", k), pcnt[k] - b[k], 0);

      // basic rise/fall, all modes
      snap();
      repeat (2) @(posedge clk_s);
      pluse_s = 1'b1;
      cr = ecnt;
      repeat (2) @(posedge clk_s);
      pluse_s = 1'b0;
      cf = ecnt;
      cyc(10);
      chk("basic_cnt_m0", pcnt[0] - b[0], 1);
      chk("basic_cnt_m2", pcnt[1] - b[1], 2);
      chk("basic_cnt_m1s3", pcnt[2] - b[2], 1);
      chk("basic_cnt_m0s4", pcnt[3] - b[3], 1);
      rng("basic_lat_m0", pe[0][b[0]] - cr, 3, 4);
      rng("basic_lat_m2_rise", pe[1][b[1]] - cr, 3, 4);
      rng("basic_lat_m2_fall", pe[1][b[1] + 1] - cf, 3, 4);
      rng("basic_lat_m1s3", pe[2][b[2]] - cf, 4, 5);
      rng("basic_lat_m0s4", pe[3][b[3]] - cr, 5, 6);
      for (int k = 0; k < 4; k++)
         chk($sformatf("basic_wide%0d", k), wide[k] - w[k], 0);
      rng("basic_level_cycles", lvl[0] - l[0], 5, 6);

      // reset while an edge is in flight
      snap();
      @(posedge clk_s);
      pluse_s = 1'b1;
      @(posedge clk_f);
      #1;
      rst_n = 1'b0;
      @(posedge clk_f);
      #1;
      rel = ecnt;
      chk("midrst_pf", int'(pf), 0);
      chk("midrst_lf", int'(lf), 0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("midrst_none%0d", k), pcnt[k] - b[k], 0);
      rst_n = 1'b1;
      cyc(10);
      chk("midrst_cnt_m0", pcnt[0] - b[0], 1);
      chk("midrst_cnt_m2", pcnt[1] - b[1], 1);
      chk("midrst_cnt_m1s3", pcnt[2] - b[2], 0);
      chk("midrst_cnt_m0s4", pcnt[3] - b[3], 1);
      chk("midrst_lat_m0", pe[0][b[0]] - rel, 3);
      chk("midrst_lat_m2", pe[1][b[1]] - rel, 3);
      chk("midrst_lat_m0s4", pe[3][b[3]] - rel, 5);
      @(posedge clk_s);
      pluse_s = 1'b0;
      cyc(12);

      // back-to-back traffic
      snap();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_s);
         pluse_s = 1'b1;
         cr6[i] = ecnt;
         @(posedge clk_s);
         pluse_s = 1'b0;
      end
      cyc(12);
      chk("b2b_cnt_m0", pcnt[0] - b[0], 10);
      chk("b2b_cnt_m2", pcnt[1] - b[1], 20);
      chk("b2b_cnt_m1s3", pcnt[2] - b[2], 10);
      chk("b2b_cnt_m0s4", pcnt[3] - b[3], 10);
      for (int k = 0; k < 4; k++)
         chk($sformatf("b2b_wide%0d", k), wide[k] - w[k], 0);
      for (int i = 0; i < 10; i++)
         rng($sformatf("b2b_lat%0d", i), pe[0][b[0] + i] - cr6[i], 3, 4);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
